change_dispenser: RTL and testbench

- Return-path counterpart to the coin-accepting vending FSM: it pays coins out instead of taking them in.
- Given a change amount in 5-cent units, it drives a coin-eject mechanism one coin at a time over a req/ack handshake, greedy 10c-first.
- It tracks hopper inventory for 10c and 5c coins, accepts refills, and reports done, or a fault with the unpaid shortfall.

---
 rtl/change_dispenser.sv | 121 ++++++++++++
 tb/tb_change_dispenser.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Coin payout controller: pays a change amount (5c units) greedily, 10c first,
// one coin per req/ack handshake, while tracking and refilling hopper inventory.
module change_dispenser #(
    parameter int AW     = 4,
    parameter int CW     = 4,
    parameter int INIT10 = 4,
    parameter int INIT5  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] amount,
    input  logic          coin_ack,
    input  logic          inc10,
    input  logic          inc5,
    output logic          eject10,
    output logic          eject5,
    output logic          busy,
    output logic          done,
    output logic          fault,
    output logic [AW-1:0] remaining,
    output logic [CW-1:0] cnt10,
    output logic [CW-1:0] cnt5
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEL    = 3'd1,
        WAIT10 = 3'd2,
        WAIT5  = 3'd3,
        DONE   = 3'd4,
        FAULT  = 3'd5
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    state_t        state_q, state_d;
    logic [AW-1:0] remaining_q, remaining_d;
    logic [CW-1:0] cnt10_q, cnt10_d;
    logic [CW-1:0] cnt5_q, cnt5_d;
    logic          pay10, pay5;

    assign pay10 = (state_q == WAIT10) && coin_ack;
    assign pay5  = (state_q == WAIT5) && coin_ack;

    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            cnt10_q     <= CW'(INIT10);
            cnt5_q      <= CW'(INIT5);
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            cnt10_q     <= cnt10_d;
            cnt5_q      <= cnt5_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = SEL;
            SEL: begin
                if (remaining_q == '0)
                    state_d = DONE;
                else if (remaining_q > AW'(1) && cnt10_q != '0)
                    state_d = WAIT10;
                else if (cnt5_q != '0)
                    state_d = WAIT5;
                else
                    state_d = FAULT;
            end
            WAIT10: if (coin_ack) state_d = SEL;
            WAIT5:  if (coin_ack) state_d = SEL;
            DONE:   state_d = IDLE;
            FAULT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A coin leaving and a refill arriving on the same edge cancel out.
    always_comb begin
        remaining_d = remaining_q;
        cnt10_d     = cnt10_q;
        cnt5_d      = cnt5_q;

        if (state_q == IDLE && start)
            remaining_d = amount;
        else if (pay10)
            remaining_d = remaining_q - AW'(2);
        else if (pay5)
            remaining_d = remaining_q - AW'(1);

        if (inc10 && !pay10) begin
            if (cnt10_q != CNT_MAX) cnt10_d = cnt10_q + CW'(1);
        end else if (pay10 && !inc10) begin
            cnt10_d = cnt10_q - CW'(1);
        end

        if (inc5 && !pay5) begin
            if (cnt5_q != CNT_MAX) cnt5_d = cnt5_q + CW'(1);
        end else if (pay5 && !inc5) begin
            cnt5_d = cnt5_q - CW'(1);
        end
    end

    always_comb begin
        eject10   = (state_q == WAIT10);
        eject5    = (state_q == WAIT5);
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        fault     = (state_q == FAULT);
        remaining = remaining_q;
        cnt10     = cnt10_q;
        cnt5      = cnt5_q;
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench: three dispensers with different reset inventories, driven one
// at a time through payouts, shortfall, refills, and mid-payout reset.
module tb_change_dispenser;

    localparam int AW = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] amount = '0;
    logic          inc10 = 1'b0;
    logic          inc5 = 1'b0;
    logic [2:0]    start_v = '0;
    logic [2:0]    ack_v = '0;

    logic [2:0]    eject10_w, eject5_w, busy_w, done_w, fault_w;
    logic [AW-1:0] rem_w   [3];
    logic [CW-1:0] cnt10_w [3];
    logic [CW-1:0] cnt5_w  [3];

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    // Instance 0: INIT 2/2, instance 1: INIT 3/0, instance 2: INIT 0/5.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        change_dispenser #(
            .AW(AW), .CW(CW),
            .INIT10(g == 0 ? 2 : (g == 1 ? 3 : 0)),
            .INIT5 (g == 0 ? 2 : (g == 1 ? 0 : 5))
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .start    (start_v[g]),
            .amount   (amount),
            .coin_ack (ack_v[g]),
            .inc10    (inc10),
            .inc5     (inc5),
            .eject10  (eject10_w[g]),
            .eject5   (eject5_w[g]),
            .busy     (busy_w[g]),
            .done     (done_w[g]),
            .fault    (fault_w[g]),
            .remaining(rem_w[g]),
            .cnt10    (cnt10_w[g]),
            .cnt5     (cnt5_w[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    // Wait for the next eject request, verify its coin type, ack it 2 cycles later.
    task automatic pay_coin(input int d, input bit is10, input string tag);
        int k = 0;
        while (!(eject10_w[d] || eject5_w[d]) && k < 8) begin
            tick();
            k++;
        end
        check({tag, "_eject_seen"}, 32'(k < 8), 1);
        check({tag, "_eject10"}, eject10_w[d], is10);
        check({tag, "_eject5"}, eject5_w[d], !is10);
        tick();
        check({tag, "_eject_held"}, eject10_w[d] | eject5_w[d], 1);
        ack_v[d] = 1'b1;
        tick();
        ack_v[d] = 1'b0;
        check({tag, "_eject_drop"}, eject10_w[d] | eject5_w[d], 0);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_rem", rem_w[0], 0);
        check("rst_cnt10", cnt10_w[0], 2);
        check("rst_cnt5", cnt5_w[0], 2);
        check("rst_busy", busy_w[0], 0);
        check("rst_outs", {eject10_w[0], eject5_w[0], done_w[0], fault_w[0]}, 0);
        check("rst_b_cnt5", cnt5_w[1], 0);
        check("rst_c_cnt10", cnt10_w[2], 0);

        // 15c from 2/2: one 10c then one 5c
        amount = 4'd3;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        check("a_busy", busy_w[0], 1);
        check("a_rem_latched", rem_w[0], 3);
        check("a_no_eject_sel", eject10_w[0] | eject5_w[0], 0);
        pay_coin(0, 1'b1, "a_coin1");
        check("a_rem_after10", rem_w[0], 1);
        check("a_cnt10_after10", cnt10_w[0], 1);
        pay_coin(0, 1'b0, "a_coin2");
        check("a_rem_after5", rem_w[0], 0);
        tick();
        check("a_done", done_w[0], 1);
        check("a_fault", fault_w[0], 0);
        tick();
        check("a_done_pulse", done_w[0], 0);
        check("a_idle", busy_w[0], 0);
        check("a_final_cnt10", cnt10_w[0], 1);
        check("a_final_cnt5", cnt5_w[0], 1);

        // Zero amount: IDLE -> SEL -> DONE, no coins
        amount = 4'd0;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        check("z_busy", busy_w[0], 1);
        check("z_not_done_yet", done_w[0], 0);
        tick();
        check("z_done", done_w[0], 1);
        check("z_no_eject", eject10_w[0] | eject5_w[0], 0);
        tick();
        check("z_idle", busy_w[0], 0);
        check("z_cnt10", cnt10_w[0], 1);
        check("z_cnt5", cnt5_w[0], 1);

        // 15c from 3/0: one 10c then shortfall of 5c
        amount = 4'd3;
        start_v[1] = 1'b1;
        tick();
        start_v[1] = 1'b0;
        pay_coin(1, 1'b1, "b_coin1");
        check("b_rem_after10", rem_w[1], 1);
        tick();
        check("b_fault", fault_w[1], 1);
        check("b_no_done", done_w[1], 0);
        check("b_no_eject", eject10_w[1] | eject5_w[1], 0);
        tick();
        check("b_fault_pulse", fault_w[1], 0);
        check("b_idle", busy_w[1], 0);
        check("b_shortfall", rem_w[1], 1);
        check("b_cnt10", cnt10_w[1], 2);

        // 20c from 0/5: four 5c coins, with a start pulse mid-payout
        amount = 4'd4;
        start_v[2] = 1'b1;
        tick();
        start_v[2] = 1'b0;
        pay_coin(2, 1'b0, "c_coin1");
        amount = 4'd7;
        start_v[2] = 1'b1;
        tick();
        start_v[2] = 1'b0;
        check("c_start_ignored", rem_w[2], 3);
        pay_coin(2, 1'b0, "c_coin2");
        check("c_rem2", rem_w[2], 2);
        pay_coin(2, 1'b0, "c_coin3");
        pay_coin(2, 1'b0, "c_coin4");
        check("c_rem4", rem_w[2], 0);
        tick();
        check("c_done", done_w[2], 1);
        tick();
        check("c_idle", busy_w[2], 0);
        check("c_cnt5", cnt5_w[2], 1);

        // Refill saturation on instance 0 (cnt5 = 1)
        inc5 = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        check("sat_cnt5_15", cnt5_w[0], 15);
        tick();
        inc5 = 1'b0;
        check("sat_cnt5_hold", cnt5_w[0], 15);

        // Refill coinciding with a 10c ack cancels out
        amount = 4'd2;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        tick();
        check("r_eject10", eject10_w[0], 1);
        ack_v[0] = 1'b1;
        inc10 = 1'b1;
        tick();
        ack_v[0] = 1'b0;
        inc10 = 1'b0;
        check("r_cnt10_net", cnt10_w[0], 1);
        check("r_rem", rem_w[0], 0);
        tick();
        check("r_done", done_w[0], 1);
        tick();

        // Stray ack in IDLE does nothing
        ack_v[0] = 1'b1;
        tick();
        ack_v[0] = 1'b0;
        check("i_busy", busy_w[0], 0);
        check("i_cnt10", cnt10_w[0], 1);
        check("i_cnt5", cnt5_w[0], 15);
        check("i_rem", rem_w[0], 0);

        // Reset while a 10c eject is pending
        amount = 4'd3;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        tick();
        check("m_eject10", eject10_w[0], 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("m_eject10_drop", eject10_w[0], 0);
        check("m_busy", busy_w[0], 0);
        check("m_rem", rem_w[0], 0);
        check("m_cnt10", cnt10_w[0], 2);
        check("m_cnt5", cnt5_w[0], 2);

        // Normal operation after reset: 5c only
        amount = 4'd1;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        pay_coin(0, 1'b0, "p_coin1");
        tick();
        check("p_done", done_w[0], 1);
        check("p_cnt5", cnt5_w[0], 1);
        check("p_cnt10", cnt10_w[0], 2);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
